// File: rtl/rotation_pkg.sv
// Shared types for the rotation stepper and its consumers (renderer sin/cos lookup).
package rotation_pkg;

  localparam int ROT_ANGLE_W = 8;
  localparam int ROT_STEP_W  = 4;

  typedef logic [ROT_ANGLE_W-1:0] angle_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } rot_state_e;

endpackage

// File: rtl/toggle_edge_detect.sv
// Turns every edge (rise or fall) of a slow divider output into a one-cycle event pulse.
module toggle_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  output logic ev
);

  logic tick_dly_q;
  logic tick_dly_d;

  always_comb begin
    tick_dly_d = tick;
    ev         = tick ^ tick_dly_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_dly_q <= 1'b0;
    end else begin
      tick_dly_q <= tick_dly_d;
    end
  end

endmodule

// File: rtl/rotation_stepper.sv
// Converts divider toggles into queued rotation-angle updates presented over valid/ready.
// Optional ROTATION_STEPPER_BOUNCE_EN: saturate and reverse direction instead of wrapping.
module rotation_stepper
  import rotation_pkg::*;
#(
  parameter int ANGLE_W     = ROT_ANGLE_W,
  parameter int STEP_W      = ROT_STEP_W,
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               enable,
  input  logic               dir,
  input  logic [STEP_W-1:0]  step,
  output logic               angle_valid,
  input  logic               angle_ready,
  output logic [ANGLE_W-1:0] angle,
  output logic               wrap,
  output logic               overrun
);

  logic ev;

  toggle_edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .ev    (ev)
  );

  rot_state_e         state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic               overrun_q, overrun_d;
  logic [PEND_W-1:0]  pending_q, pending_d;

  logic               start;
  logic               eff_dir;
  logic [ANGLE_W:0]   step_ext;
  logic [ANGLE_W:0]   sum_ext;
  logic               over;
  logic [ANGLE_W-1:0] upd_angle;

`ifdef ROTATION_STEPPER_BOUNCE_EN
  logic bounce_q, bounce_d;
  assign eff_dir = dir ^ bounce_q;
`else
  assign eff_dir = dir;
`endif

  assign start    = (state_q == IDLE) && (pending_q != '0) && enable;
  assign step_ext = {{(ANGLE_W + 1 - STEP_W){1'b0}}, step};

  // Extra top bit of the widened sum is the carry (increment) or borrow (decrement).
  always_comb begin
    if (eff_dir) begin
      sum_ext = {1'b0, angle_q} - step_ext;
    end else begin
      sum_ext = {1'b0, angle_q} + step_ext;
    end
    over      = sum_ext[ANGLE_W];
    upd_angle = sum_ext[ANGLE_W-1:0];
`ifdef ROTATION_STEPPER_BOUNCE_EN
    if (over) begin
      upd_angle = eff_dir ? '0 : '1;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    valid_d   = valid_q;
    wrap_d    = 1'b0;
    pending_d = pending_q;
    overrun_d = overrun_q;
`ifdef ROTATION_STEPPER_BOUNCE_EN
    bounce_d  = bounce_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          angle_d = upd_angle;
          wrap_d  = over;
          valid_d = 1'b1;
          state_d = PRESENT;
`ifdef ROTATION_STEPPER_BOUNCE_EN
          if (over) begin
            bounce_d = ~bounce_q;
          end
`endif
        end
      end
      PRESENT: begin
        if (angle_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // An event arriving alongside a dequeue leaves the count unchanged and is never dropped.
    if (!enable) begin
      pending_d = '0;
    end else if (ev && !start) begin
      if (pending_q < PEND_W'(MAX_PENDING)) begin
        pending_d = pending_q + PEND_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (!ev && start) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= '0;
`ifdef ROTATION_STEPPER_BOUNCE_EN
      bounce_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
`ifdef ROTATION_STEPPER_BOUNCE_EN
      bounce_q  <= bounce_d;
`endif
    end
  end

  assign angle_valid = valid_q;
  assign angle       = angle_q;
  assign wrap        = wrap_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_rotation_stepper.sv
// Directed bench for rotation_stepper: cycle-by-cycle behavioural model plus literal checkpoints.
module tb_rotation_stepper;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       enable = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] step = 4'd0;
  logic       angle_valid;
  logic       angle_ready = 1'b0;
  logic [7:0] angle;
  logic       wrap;
  logic       overrun;

  int vectors = 0;
  int miscompares = 0;

  rotation_stepper dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .dir         (dir),
    .step        (step),
    .angle_valid (angle_valid),
    .angle_ready (angle_ready),
    .angle       (angle),
    .wrap        (wrap),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  // Behavioural model: integer angle, event counter and a busy flag for the presented update.
  int m_angle = 0;
  int m_pending = 0;
  bit m_valid = 0;
  bit m_wrap = 0;
  bit m_overrun = 0;
  bit m_tick = 0;
`ifdef ROTATION_STEPPER_BOUNCE_EN
  bit m_bounce = 0;
`endif

  always @(posedge clock) begin
    int p;
    int s;
    bit ev;
    bit start;
    bit hs;
    bit ed;
    if (!reset) begin
      m_angle = 0; m_pending = 0; m_valid = 0; m_wrap = 0; m_overrun = 0; m_tick = 0;
`ifdef ROTATION_STEPPER_BOUNCE_EN
      m_bounce = 0;
`endif
    end else begin
      ev     = (tick != m_tick);
      m_tick = tick;
      start  = !m_valid && (m_pending > 0) && enable;
      hs     = m_valid && angle_ready;
      m_wrap = 0;
      if (start) begin
        ed = dir;
`ifdef ROTATION_STEPPER_BOUNCE_EN
        ed = dir ^ m_bounce;
`endif
        s = ed ? (m_angle - int'(step)) : (m_angle + int'(step));
        if (s < 0 || s > 255) begin
          m_wrap = 1;
`ifdef ROTATION_STEPPER_BOUNCE_EN
          m_angle  = ed ? 0 : 255;
          m_bounce = !m_bounce;
`else
          m_angle = (s + 256) % 256;
`endif
        end else begin
          m_angle = s;
        end
      end
      p = m_pending;
      if (start) p--;
      if (!enable) p = 0;
      else if (ev) begin
        if (p < 3) p++;
        else m_overrun = 1;
      end
      m_pending = p;
      if (start) m_valid = 1;
      else if (hs) m_valid = 0;
    end
  end

  always @(negedge clock) begin
    vectors += 4;
    if (angle_valid !== m_valid) begin
      miscompares++;
      $display("FAIL model_valid t=%0t: got %0b, expected %0b", $time, angle_valid, m_valid);
    end
    if (angle !== 8'(m_angle)) begin
      miscompares++;
      $display("FAIL model_angle t=%0t: got %0d, expected %0d", $time, angle, m_angle);
    end
    if (wrap !== m_wrap) begin
      miscompares++;
      $display("FAIL model_wrap t=%0t: got %0b, expected %0b", $time, wrap, m_wrap);
    end
    if (overrun !== m_overrun) begin
      miscompares++;
      $display("FAIL model_overrun t=%0t: got %0b, expected %0b", $time, overrun, m_overrun);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic reset_dut();
    reset = 1'b0; tick = 1'b0; enable = 1'b0; angle_ready = 1'b0;
    cyc(2);
    chk("reset_angle", int'(angle), 0);
    chk("reset_valid", int'(angle_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset = 1'b1;
    enable = 1'b1;
    cyc(1);
  endtask

  // One tick edge with ready high; checks latency, angle and wrap of the resulting update.
  task automatic do_update(input bit d, input int st, input int exp_angle, input int exp_wrap);
    int n;
    dir = d; step = 4'(st); angle_ready = 1'b1;
    tick = ~tick;
    cyc(1);
    n = 0;
    while (!angle_valid && n < 20) begin
      cyc(1);
      n++;
    end
    chk("update_latency", n, 1);
    chk("update_angle", int'(angle), exp_angle);
    chk("update_wrap", int'(wrap), exp_wrap);
    cyc(1);
  endtask

  task automatic count_hs(input int cycles, input int tog_a, input int tog_b, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (angle_valid && angle_ready) cnt++;
      if (i == tog_a || i == tog_b) tick = ~tick;
      cyc(1);
    end
  endtask

  initial begin
    int cnt;
    cyc(1);

    // Basic stepping.
    reset_dut();
    for (int k = 1; k <= 5; k++) do_update(1'b0, 4, 4 * k, 0);
    chk("basic_overrun", int'(overrun), 0);

`ifdef ROTATION_STEPPER_BOUNCE_EN
    reset_dut();
    for (int k = 1; k <= 16; k++) do_update(1'b0, 15, 15 * k, 0);
    do_update(1'b0, 10, 250, 0);
    do_update(1'b0, 4, 254, 0);
    do_update(1'b0, 4, 255, 1);
    do_update(1'b0, 4, 251, 0);
`else
    // Wrap in both directions, starting from angle 20.
    do_update(1'b1, 12, 8, 0);
    do_update(1'b1, 12, 252, 1);
    do_update(1'b0, 4, 0, 1);
    do_update(1'b0, 2, 2, 0);
    do_update(1'b1, 4, 254, 1);
    do_update(1'b1, 0, 254, 0);
`endif

    // Renderer stalled: 5 edges, 1 presented + 3 queued + 1 dropped.
    reset_dut();
    dir = 1'b0; step = 4'd4; angle_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick = ~tick;
      cyc(2);
    end
    chk("stall_overrun", int'(overrun), 1);
    chk("stall_valid", int'(angle_valid), 1);
    chk("stall_angle", int'(angle), 4);
    angle_ready = 1'b1;
    count_hs(20, -1, -1, cnt);
    chk("stall_handshakes", cnt, 4);
    chk("stall_final_angle", int'(angle), 16);
    chk("stall_overrun_sticky", int'(overrun), 1);

    // Event coincident with a dequeue while the queue is full.
    reset_dut();
    dir = 1'b0; step = 4'd4; angle_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick = ~tick;
      cyc(2);
    end
    cyc(2);
    chk("full_overrun_before", int'(overrun), 0);
    angle_ready = 1'b1;
    count_hs(20, 1, -1, cnt);
    chk("full_handshakes", cnt, 5);
    chk("full_overrun_after", int'(overrun), 0);
    chk("full_final_angle", int'(angle), 20);

    // Disable with a transaction in flight and two queued.
    reset_dut();
    dir = 1'b0; step = 4'd4; angle_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick = ~tick;
      cyc(2);
    end
    enable = 1'b0;
    cyc(3);
    chk("disable_valid_held", int'(angle_valid), 1);
    angle_ready = 1'b1;
    count_hs(20, 2, 5, cnt);
    chk("disable_handshakes", cnt, 1);
    chk("disable_angle", int'(angle), 4);
    chk("disable_valid_end", int'(angle_valid), 0);

    // Reset while an update is presented and overrun is set.
    reset_dut();
    dir = 1'b0; step = 4'd4; angle_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick = ~tick;
      cyc(2);
    end
    chk("midrst_pre_valid", int'(angle_valid), 1);
    chk("midrst_pre_overrun", int'(overrun), 1);
    reset = 1'b0; tick = 1'b0; angle_ready = 1'b1;
    cyc(1);
    chk("midrst_angle", int'(angle), 0);
    chk("midrst_valid", int'(angle_valid), 0);
    chk("midrst_overrun", int'(overrun), 0);
    reset = 1'b1;
    cyc(10);
    chk("midrst_no_pending", int'(angle_valid), 0);
    chk("midrst_angle_after", int'(angle), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rotation_stepper.md
Name: rotation_stepper

Overview:
- Consumes the slow toggling output of the clock divider and converts each toggle into one rotation-angle update for the 3D object renderer.
- Detects divider toggles in the fast clock domain and accumulates them as pending steps.
- Presents each updated angle to the renderer over a valid/ready handshake.
- Flags lost steps when the renderer falls too far behind.

Parameters:
- ANGLE_W, 8, width of angle; angle arithmetic is modulo 2^ANGLE_W.
- STEP_W, 4, width of per-update step magnitude.
- MAX_PENDING, 3, max queued unserviced ticks (>=1).
- PEND_W, 2, width of pending counter; must hold MAX_PENDING.

Ports:
- clock, in, 1, system clock (same clock as the divider).
- reset, in, 1, synchronous, active-low reset.
- tick, in, 1, divider output; every edge (rise or fall) is one step event.
- enable, in, 1, high = accept step events.
- dir, in, 1, 0 = increment angle, 1 = decrement.
- step, in, STEP_W, step magnitude; sampled at update time.
- angle_valid, out, 1, angle holds a new value for the renderer.
- angle_ready, in, 1, renderer accepts the angle.
- angle, out, ANGLE_W, current rotation angle.
- wrap, out, 1, one-cycle pulse when an update crosses the modulus.
- overrun, out, 1, sticky; a step event was dropped.

Behaviour:
- Reset, sampled on a clock edge with reset==0:
  - angle=0, angle_valid=0, wrap=0, overrun=0.
  - pending=0, tick_d=0, state=IDLE.
  - The divider also resets its output to 0, so no spurious event follows reset.
- Event detection:
  - Registered tick_d; ev = tick ^ tick_d.
  - One cycle of detection latency; one event per tick edge.
- Pending counter:
  - ev && enable && pending<MAX_PENDING: pending+1.
  - ev && enable && pending==MAX_PENDING: event dropped, overrun<=1. Overrun clears only on reset.
  - Event and dequeue in the same cycle: net zero change; never counts as overrun.
  - enable==0: ev ignored and pending cleared to 0 next cycle. A transaction already in PRESENT completes normally.
- State IDLE:
  - If pending>0: update the angle, pending-1, go to PRESENT, assert angle_valid next cycle.
  - Update: angle <= angle + step (dir=0) or angle - step (dir=1), truncated to ANGLE_W.
  - wrap <= carry-out (increment) or borrow (decrement) of that update, for exactly one cycle.
  - step==0: the update still occurs (angle unchanged, handshake performed, wrap=0).
- State PRESENT:
  - angle_valid=1; angle stable until handshake.
  - angle_ready==1: handshake completes that cycle; angle_valid drops next cycle; go to IDLE.
  - Minimum one idle cycle between updates, giving a throughput of one update per 2 cycles.
  - angle_ready while in IDLE has no effect.
- Latency: tick edge at cycle N → ev at N+1 → angle/valid updated at N+2 (pending was 0, state IDLE).
- Mid-operation reset: everything returns to reset values on the next edge; no handshake completes in that cycle.

Optional Feature:
- Macro: ROTATION_STEPPER_BOUNCE_EN.
- Defined:
  - An internal bounce flag (reset 0) is XORed with dir to give the effective direction.
  - If an update would carry or borrow, angle saturates at 2^ANGLE_W-1 (increment) or 0 (decrement) instead of wrapping.
  - The bounce flag toggles, and wrap pulses to mark the bounce.
  - Produces ping-pong rocking of the object.
- Not defined: pure modulo wrap as above; no bounce flag logic.

Decomposition:
- Shared package (rotation_pkg):
  - Default ANGLE_W/STEP_W.
  - State encoding typedef (IDLE, PRESENT).
  - Angle typedef, reused by the renderer's sine/cosine lookup.
- Sub-module toggle_edge_detect (tick → single-cycle ev pulse): natural, reusable by other divider consumers.
- Pending counter and FSM stay in the top module.

Test Plan:
- Reset then enable=1, dir=0, step=4, renderer ready always high, 5 tick edges → angle 4,8,12,16,20; one valid pulse each; overrun=0.
- angle=252, step=4, dir=0, one edge → angle=0, wrap high for exactly 1 cycle. Same with dir=1 from angle=2, step=4 → angle=254, wrap pulse.
- angle_ready held low, 5 edges with MAX_PENDING=3 → first update presented, 3 pending, overrun=1 after the 5th edge. Release ready → exactly 3 further updates (4 total); overrun stays 1.
- Tick edge in the same cycle as a dequeue, with pending=MAX_PENDING → pending unchanged, overrun stays 0.
- enable=0 with 2 pending and a transaction in PRESENT → current angle completes on ready; no further updates; later edges ignored.
- With ROTATION_STEPPER_BOUNCE_EN defined: angle=250, step=4, dir=0, 3 edges → 254, 255 (wrap pulse), 251.
- Reset asserted while angle_valid=1 → next cycle angle=0, valid=0, overrun=0, pending=0.
